// File: rtl/traffic_pkg.sv
// traffic_pkg: phase codes and default timing shared by the sequencer and the light datapath
package traffic_pkg;
  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALLRED_EW = 3'd2,
    ST_EW_LEFT   = 3'd3,
    ST_EW_GREEN  = 3'd4,
    ST_EW_YELLOW = 3'd5,
    ST_ALLRED_NS = 3'd6,
    ST_NS_LEFT   = 3'd7
  } phase_t;
  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_TW       = 8;
  localparam int unsigned DEF_GREEN_T  = 5;
  localparam int unsigned DEF_YELLOW_T = 2;
  localparam int unsigned DEF_ALLRED_T = 1;
  localparam int unsigned DEF_LEFT_T   = 3;
  function automatic int unsigned clamp1(input int unsigned d);
    return d == 0 ? 1 : d;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing one tick every CLK_DIV cycles, restartable on phase change
module tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic hold,
  input  logic clr,
  output logic tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic          last;
  assign last = cnt == CW'(CLK_DIV - 1);
  assign tick = !hold && last;
  // count 0..CLK_DIV-1, wrapping on the tick and restarting on every phase change
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (!hold) cnt <= (clr || last) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: timed eight-phase intersection sequencer with demand rest and left-turn skipping
import traffic_pkg::*;
module traffic_phase_sequencer #(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned TW       = DEF_TW,
  parameter int unsigned GREEN_T  = DEF_GREEN_T,
  parameter int unsigned YELLOW_T = DEF_YELLOW_T,
  parameter int unsigned ALLRED_T = DEF_ALLRED_T,
  parameter int unsigned LEFT_T   = DEF_LEFT_T
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       hold,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ns_left_req,
  input  logic       ew_left_req,
  output logic [2:0] state_out,
  output logic       phase_start,
  output logic       ns_left_pend,
  output logic       ew_left_pend
);
  localparam logic [TW-1:0] G  = TW'(clamp1(GREEN_T));
  localparam logic [TW-1:0] Y  = TW'(clamp1(YELLOW_T));
  localparam logic [TW-1:0] AR = TW'(clamp1(ALLRED_T));
  localparam logic [TW-1:0] L  = TW'(clamp1(LEFT_T));
  phase_t        state, nxt;
  logic [TW-1:0] timer, timer_n;
  logic          tick, expire, go, ps_q, ns_pend_n, ew_pend_n;
  function automatic logic [TW-1:0] dur(input phase_t p);
    return p[1:0] == 2'd0 ? G : p[1:0] == 2'd1 ? Y : p[1:0] == 2'd2 ? AR : L;
  endfunction
  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .hold   (hold),
    .clr    (go),
    .tick   (tick)
  );
  // next phase on expiry, timer reload/decrement and pending-flag set/clear
  always_comb begin
    nxt = ST_ALLRED_NS;
    case (state)
      ST_NS_GREEN:  nxt = (ew_car | ew_left_pend) ? ST_NS_YELLOW : ST_NS_GREEN;
      ST_NS_YELLOW: nxt = ST_ALLRED_EW;
      ST_ALLRED_EW: nxt = ew_left_pend ? ST_EW_LEFT : ST_EW_GREEN;
      ST_EW_LEFT:   nxt = ST_EW_GREEN;
      ST_EW_GREEN:  nxt = (ns_car | ns_left_pend) ? ST_EW_YELLOW : ST_EW_GREEN;
      ST_EW_YELLOW: nxt = ST_ALLRED_NS;
      ST_ALLRED_NS: nxt = ns_left_pend ? ST_NS_LEFT : ST_NS_GREEN;
      ST_NS_LEFT:   nxt = ST_NS_GREEN;
      default:      nxt = ST_ALLRED_NS;
    endcase
    expire    = tick && timer <= TW'(1);
    go        = expire && nxt != state;
    timer_n   = go ? dur(nxt) : (tick && timer > TW'(1)) ? timer - 1'b1 : timer;
    ew_pend_n = ((go && nxt == ST_EW_LEFT) || state == ST_EW_LEFT) ? 1'b0 : ew_left_pend | ew_left_req;
    ns_pend_n = ((go && nxt == ST_NS_LEFT) || state == ST_NS_LEFT) ? 1'b0 : ns_left_pend | ns_left_req;
  end
  // phase, timer and pending registers; hold freezes everything but the start pulse
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state        <= ST_ALLRED_NS;
      timer        <= AR;
      ps_q         <= 1'b0;
      ns_left_pend <= 1'b0;
      ew_left_pend <= 1'b0;
    end else begin
      ps_q <= go;
      if (!hold) begin
        state        <= go ? nxt : state;
        timer        <= timer_n;
        ns_left_pend <= ns_pend_n;
        ew_left_pend <= ew_pend_n;
      end
    end
  assign state_out   = state;
  assign phase_start = ps_q && !hold;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: directed timeline checks of the phase sequencer
module tb_traffic_phase_sequencer;
  logic       clk = 1'b0, resetn = 1'b0, hold = 1'b0;
  logic       ns_car = 1'b1, ew_car = 1'b1, ns_left_req = 1'b0, ew_left_req = 1'b0;
  logic [2:0] state_out;
  logic       phase_start, ns_left_pend, ew_left_pend;
  int         total = 0, pass = 0;
  traffic_phase_sequencer dut (
    .clk          (clk),
    .resetn       (resetn),
    .hold         (hold),
    .ns_car       (ns_car),
    .ew_car       (ew_car),
    .ns_left_req  (ns_left_req),
    .ew_left_req  (ew_left_req),
    .state_out    (state_out),
    .phase_start  (phase_start),
    .ns_left_pend (ns_left_pend),
    .ew_left_pend (ew_left_pend)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic phase(input int st, input int len, input bit first);
    int n = 0;
    chk($sformatf("state_%0d", st), state_out, st);
    if (first) chk($sformatf("start_%0d", st), phase_start, 1);
    while (state_out == st && n < 200) begin
      if (n == 1) chk($sformatf("start_low_%0d", st), phase_start, 0);
      n++;
      @(negedge clk);
    end
    chk($sformatf("len_%0d", st), n, len);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_state", state_out, 6);
    chk("rst_start", phase_start, 0);
    chk("rst_nsp", ns_left_pend, 0);
    chk("rst_ewp", ew_left_pend, 0);
    resetn = 1'b1;
    phase(6, 4, 0);
    phase(0, 20, 1);
    phase(1, 8, 1);
    phase(2, 4, 1);
    phase(4, 20, 1);
    phase(5, 8, 1);
    phase(6, 4, 1);
    ew_left_req = 1'b1;
    @(negedge clk);
    ew_left_req = 1'b0;
    chk("ewp_set", ew_left_pend, 1);
    phase(0, 19, 0);
    phase(1, 8, 1);
    phase(2, 4, 1);
    chk("ewp_clr", ew_left_pend, 0);
    phase(3, 12, 1);
    phase(4, 20, 1);
    ew_car = 1'b0;
    phase(5, 8, 1);
    phase(6, 4, 1);
    chk("rest_state", state_out, 0);
    repeat (50) @(negedge clk);
    chk("rest_hold", state_out, 0);
    ew_car = 1'b1;
    n = 0;
    while (state_out == 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("rest_release", n, 2);
    phase(1, 8, 1);
    phase(2, 4, 1);
    ns_left_req = 1'b1;
    phase(4, 20, 1);
    chk("nsp_set", ns_left_pend, 1);
    phase(5, 8, 1);
    phase(6, 4, 1);
    chk("nsp_clr", ns_left_pend, 0);
    phase(7, 12, 1);
    ns_left_req = 1'b0;
    chk("nsp_served", ns_left_pend, 0);
    phase(0, 20, 1);
    phase(1, 8, 1);
    phase(2, 4, 1);
    phase(4, 20, 1);
    phase(5, 8, 1);
    phase(6, 4, 1);
    phase(0, 20, 1);
    phase(1, 8, 1);
    phase(2, 4, 1);
    ew_left_req = 1'b1;
    @(negedge clk);
    ew_left_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_state", state_out, 4);
    chk("mid_ewp", ew_left_pend, 1);
    resetn = 1'b0;
    #1;
    chk("async_state", state_out, 6);
    chk("async_ewp", ew_left_pend, 0);
    chk("async_start", phase_start, 0);
    @(negedge clk);
    resetn = 1'b1;
    phase(6, 4, 0);
    phase(0, 20, 1);
    phase(1, 8, 1);
    phase(2, 4, 1);
    phase(4, 20, 1);
    phase(5, 8, 1);
    phase(6, 4, 1);
    phase(0, 20, 1);
    chk("hold_entry", state_out, 1);
    n = 0;
    while (state_out == 1 && n < 100) begin
      if (n == 2) hold = 1'b1;
      if (n == 12) hold = 1'b0;
      if (hold) begin
        #1;
        chk("hold_state", state_out, 1);
        chk("hold_start", phase_start, 0);
      end
      n++;
      @(negedge clk);
    end
    chk("hold_len", n, 18);
    chk("after_hold", state_out, 2);
    chk("after_hold_start", phase_start, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
